// File: rtl/gomoku_turn_ctrl_if.sv
// Key-pulse inputs and board/status/cursor outputs shared between the game
// sequencer and its driver (key debouncer side) / renderer side.
interface gomoku_turn_ctrl_if #(
    parameter int BOARD_N = 16
);
    localparam int PW = $clog2(BOARD_N);

    logic                         mv_up;
    logic                         mv_down;
    logic                         mv_left;
    logic                         mv_right;
    logic                         place;
    logic [BOARD_N*BOARD_N*2-1:0] board;
    logic [1:0]                   gaming_status;
    logic [PW-1:0]                pointer_loc_x;
    logic [PW-1:0]                pointer_loc_y;
    logic                         cur_player;
    logic                         busy;

    modport master (
        output mv_up, mv_down, mv_left, mv_right, place,
        input  board, gaming_status, pointer_loc_x, pointer_loc_y, cur_player, busy
    );

    modport slave (
        input  mv_up, mv_down, mv_left, mv_right, place,
        output board, gaming_status, pointer_loc_x, pointer_loc_y, cur_player, busy
    );
endinterface

// File: rtl/gomoku_turn_ctrl.sv
// Gomoku sequencer: cursor movement, turn arbitration, stone placement and a
// cell-per-cycle five-in-a-row walk in four directions after each placement.
module gomoku_turn_ctrl #(
    parameter int BOARD_N = 16,
    parameter int WIN_LEN = 5,
    parameter int PTR_X0  = 7,
    parameter int PTR_Y0  = 7
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    gomoku_turn_ctrl_if.slave bus
);
    localparam int PW    = $clog2(BOARD_N);
    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IW    = $clog2(CELLS);
    localparam int CW    = $clog2(WIN_LEN);
    localparam int RW    = CW + 1;
    localparam int SW    = $clog2(CELLS + 1);

    typedef enum logic [1:0] {PLAY, WRITE, CHECK, OVER} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] ptr_x_reg, ptr_x_next, ptr_y_reg, ptr_y_next;
    logic [PW-1:0] px_reg, px_next, py_reg, py_next;
    logic [PW-1:0] walk_x_reg, walk_x_next, walk_y_reg, walk_y_next;
    logic [CW-1:0] pos_cnt_reg, pos_cnt_next, neg_cnt_reg, neg_cnt_next;
    logic [SW-1:0] count_reg, count_next;
    logic [1:0]    status_reg, status_next, stone_reg, stone_next;
    logic [1:0]    dir_reg, dir_next;
    logic          player_reg, player_next, neg_reg, neg_next;
    logic          wr_en;

    logic [CELLS*2-1:0] board_vec;

    function automatic logic [IW-1:0] cell_idx(input logic [PW-1:0] x, input logic [PW-1:0] y);
        return IW'(int'(y) * BOARD_N + int'(x));
    endfunction

    logic [IW-1:0] wr_idx;
    assign wr_idx = cell_idx(px_reg, py_reg);

    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
            logic [1:0] cell_reg;
            always_ff @(posedge CLOCK_50 or negedge Reset) begin
                if (!Reset)
                    cell_reg <= 2'b00;
                else if (wr_en && wr_idx == IW'(gi))
                    cell_reg <= stone_reg;
            end
            assign board_vec[gi*2 +: 2] = cell_reg;
        end
    endgenerate

    // Step vector for the current direction; negated on the second half-walk.
    logic signed [1:0] step_dx, step_dy;
    always_comb begin
        step_dx = 2'sd1;
        step_dy = 2'sd0;
        case (dir_reg)
            2'd0:    begin step_dx = 2'sd1; step_dy = 2'sd0;  end
            2'd1:    begin step_dx = 2'sd0; step_dy = 2'sd1;  end
            2'd2:    begin step_dx = 2'sd1; step_dy = 2'sd1;  end
            default: begin step_dx = 2'sd1; step_dy = -2'sd1; end
        endcase
        if (neg_reg) begin
            step_dx = -step_dx;
            step_dy = -step_dy;
        end
    end

    // One extra bit so stepping below 0 lands out of range instead of wrapping.
    logic [PW:0]   nx, ny;
    logic          in_bounds, hit, walk_done;
    logic [1:0]    probe_cell, cur_cell;
    logic [CW-1:0] walk_cnt, walk_cnt_inc;
    logic [RW-1:0] run;

    assign nx         = {1'b0, walk_x_reg} + {{(PW-1){step_dx[1]}}, step_dx};
    assign ny         = {1'b0, walk_y_reg} + {{(PW-1){step_dy[1]}}, step_dy};
    assign in_bounds  = (int'(nx) < BOARD_N) && (int'(ny) < BOARD_N);
    assign probe_cell = board_vec[{cell_idx(nx[PW-1:0], ny[PW-1:0]), 1'b0} +: 2];
    assign cur_cell   = board_vec[{cell_idx(ptr_x_reg, ptr_y_reg), 1'b0} +: 2];
    assign hit        = in_bounds && (probe_cell == stone_reg);
    assign walk_cnt     = neg_reg ? neg_cnt_reg : pos_cnt_reg;
    assign walk_cnt_inc = walk_cnt + CW'(hit);
    assign walk_done    = !hit || (walk_cnt_inc == CW'(WIN_LEN - 1));
    assign run          = RW'(1) + RW'(pos_cnt_reg) + RW'(walk_cnt_inc);

    always_comb begin
        state_next   = state_reg;
        ptr_x_next   = ptr_x_reg;
        ptr_y_next   = ptr_y_reg;
        px_next      = px_reg;
        py_next      = py_reg;
        walk_x_next  = walk_x_reg;
        walk_y_next  = walk_y_reg;
        pos_cnt_next = pos_cnt_reg;
        neg_cnt_next = neg_cnt_reg;
        count_next   = count_reg;
        status_next  = status_reg;
        stone_next   = stone_reg;
        dir_next     = dir_reg;
        player_next  = player_reg;
        neg_next     = neg_reg;
        wr_en        = 1'b0;

        case (state_reg)
            PLAY: begin
                if (bus.mv_up) begin
                    if (ptr_y_reg != '0) ptr_y_next = ptr_y_reg - 1'b1;
                end else if (bus.mv_down) begin
                    if (ptr_y_reg != PW'(BOARD_N - 1)) ptr_y_next = ptr_y_reg + 1'b1;
                end else if (bus.mv_left) begin
                    if (ptr_x_reg != '0) ptr_x_next = ptr_x_reg - 1'b1;
                end else if (bus.mv_right) begin
                    if (ptr_x_reg != PW'(BOARD_N - 1)) ptr_x_next = ptr_x_reg + 1'b1;
                end else if (bus.place && cur_cell == 2'b00) begin
                    px_next    = ptr_x_reg;
                    py_next    = ptr_y_reg;
                    stone_next = player_reg ? 2'b10 : 2'b01;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_en        = 1'b1;
                count_next   = count_reg + SW'(1);
                dir_next     = 2'd0;
                neg_next     = 1'b0;
                pos_cnt_next = '0;
                neg_cnt_next = '0;
                walk_x_next  = px_reg;
                walk_y_next  = py_reg;
                state_next   = CHECK;
            end
            CHECK: begin
                if (hit) begin
                    walk_x_next = nx[PW-1:0];
                    walk_y_next = ny[PW-1:0];
                    if (neg_reg) neg_cnt_next = walk_cnt_inc;
                    else         pos_cnt_next = walk_cnt_inc;
                end
                if (walk_done) begin
                    walk_x_next = px_reg;
                    walk_y_next = py_reg;
                    if (!neg_reg) begin
                        neg_next = 1'b1;
                    end else if (run >= RW'(WIN_LEN)) begin
                        status_next = stone_reg;
                        state_next  = OVER;
                    end else if (dir_reg == 2'd3) begin
                        if (count_reg == SW'(CELLS)) begin
                            status_next = 2'b11;
                            state_next  = OVER;
                        end else begin
                            player_next = ~player_reg;
                            state_next  = PLAY;
                        end
                    end else begin
                        dir_next     = dir_reg + 2'd1;
                        neg_next     = 1'b0;
                        pos_cnt_next = '0;
                        neg_cnt_next = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= PLAY;
            ptr_x_reg   <= PW'(PTR_X0);
            ptr_y_reg   <= PW'(PTR_Y0);
            px_reg      <= '0;
            py_reg      <= '0;
            walk_x_reg  <= '0;
            walk_y_reg  <= '0;
            pos_cnt_reg <= '0;
            neg_cnt_reg <= '0;
            count_reg   <= '0;
            status_reg  <= 2'b00;
            stone_reg   <= 2'b00;
            dir_reg     <= 2'd0;
            player_reg  <= 1'b0;
            neg_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_x_reg   <= ptr_x_next;
            ptr_y_reg   <= ptr_y_next;
            px_reg      <= px_next;
            py_reg      <= py_next;
            walk_x_reg  <= walk_x_next;
            walk_y_reg  <= walk_y_next;
            pos_cnt_reg <= pos_cnt_next;
            neg_cnt_reg <= neg_cnt_next;
            count_reg   <= count_next;
            status_reg  <= status_next;
            stone_reg   <= stone_next;
            dir_reg     <= dir_next;
            player_reg  <= player_next;
            neg_reg     <= neg_next;
        end
    end

    assign bus.board         = board_vec;
    assign bus.gaming_status = status_reg;
    assign bus.pointer_loc_x = ptr_x_reg;
    assign bus.pointer_loc_y = ptr_y_reg;
    assign bus.cur_player    = player_reg;
    assign bus.busy          = (state_reg == WRITE) || (state_reg == CHECK);
endmodule

// File: tb/tb_gomoku_turn_ctrl.sv
// Directed bench for gomoku_turn_ctrl: cursor, turns, wins in several
// directions, overline, edge-bounded row, reset mid-check and a full-board draw.
module tb_gomoku_turn_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gomoku_turn_ctrl_if #(.BOARD_N(16)) bus();

    gomoku_turn_ctrl #(
        .BOARD_N(16), .WIN_LEN(5), .PTR_X0(7), .PTR_Y0(7)
    ) dut (
        .CLOCK_50(clk),
        .Reset   (rst_n),
        .bus     (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [511:0] exp_board;
    int         exp_x, exp_y;
    logic       exp_player;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.mv_up = 0; bus.mv_down = 0; bus.mv_left = 0; bus.mv_right = 0; bus.place = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        exp_board = '0; exp_x = 7; exp_y = 7; exp_player = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive one cycle of key inputs, return at the following negedge.
    task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic p);
        bus.mv_up = u; bus.mv_down = d; bus.mv_left = l; bus.mv_right = r; bus.place = p;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic move_to(input int x, input int y);
        while (exp_x < x) begin pulse(0, 0, 0, 1, 0); exp_x++; end
        while (exp_x > x) begin pulse(0, 0, 1, 0, 0); exp_x--; end
        while (exp_y < y) begin pulse(0, 1, 0, 0, 0); exp_y++; end
        while (exp_y > y) begin pulse(1, 0, 0, 0, 0); exp_y--; end
    endtask

    task automatic place_at(input int x, input int y, input logic [1:0] exp_status);
        int   cyc;
        logic written;
        move_to(x, y);
        checks++;
        if (bus.pointer_loc_x !== 4'(x) || bus.pointer_loc_y !== 4'(y)) begin
            errors++;
            $display("FAIL pointer: got (%0d,%0d) required (%0d,%0d)", bus.pointer_loc_x, bus.pointer_loc_y, x, y);
        end
        written = (exp_board[(x*2 + y*32) +: 2] == 2'b00);
        if (written) exp_board[(x*2 + y*32) +: 2] = exp_player ? 2'b10 : 2'b01;
        pulse(0, 0, 0, 0, 1);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (written ? (cyc < 1 || cyc > 34) : (cyc != 0)) begin
            errors++;
            $display("FAIL busy_len (%0d,%0d): got %0d cycles required %s", x, y, cyc, written ? "1..34" : "0");
        end
        if (written && exp_status == 2'b00) exp_player = ~exp_player;
        checks++;
        if (bus.gaming_status !== exp_status || bus.cur_player !== exp_player) begin
            errors++;
            $display("FAIL status (%0d,%0d): got status=%b player=%b required status=%b player=%b",
                     x, y, bus.gaming_status, bus.cur_player, exp_status, exp_player);
        end
        checks++;
        if (bus.board !== exp_board) begin
            errors++;
            $display("FAIL board (%0d,%0d): got %h required %h", x, y, bus.board, exp_board);
        end
        $display("place (%0d,%0d) busy=%0d status=%b player=%b", x, y, cyc, bus.gaming_status, bus.cur_player);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.board !== '0 || bus.gaming_status !== 2'b00 || bus.pointer_loc_x !== 4'd7 ||
            bus.pointer_loc_y !== 4'd7 || bus.cur_player !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: got status=%b ptr=(%0d,%0d) player=%b busy=%b board_nz=%b required 00 (7,7) 0 0 0",
                     bus.gaming_status, bus.pointer_loc_x, bus.pointer_loc_y, bus.cur_player, bus.busy, |bus.board);
        end
        $display("reset: status=%b ptr=(%0d,%0d)", bus.gaming_status, bus.pointer_loc_x, bus.pointer_loc_y);
    endtask

    task automatic test_cursor();
        for (int i = 0; i < 8; i++) pulse(0, 0, 1, 0, 0);
        checks++;
        if (bus.pointer_loc_x !== 4'd0) begin
            errors++;
            $display("FAIL left_saturate: got x=%0d required 0", bus.pointer_loc_x);
        end
        pulse(1, 1, 0, 0, 0);
        checks++;
        if (bus.pointer_loc_y !== 4'd6 || bus.pointer_loc_x !== 4'd0) begin
            errors++;
            $display("FAIL up_down_prio: got (%0d,%0d) required (0,6)", bus.pointer_loc_x, bus.pointer_loc_y);
        end
        pulse(0, 0, 0, 1, 1);
        checks++;
        if (bus.pointer_loc_x !== 4'd1 || bus.board !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL move_place: got x=%0d busy=%b board_nz=%b required x=1 busy=0 board_nz=0",
                     bus.pointer_loc_x, bus.busy, |bus.board);
        end
        $display("cursor: ptr=(%0d,%0d)", bus.pointer_loc_x, bus.pointer_loc_y);
    endtask

    task automatic test_place_turn();
        do_reset();
        place_at(7, 7, 2'b00);
        checks++;
        if (bus.board[238 +: 2] !== 2'b01) begin
            errors++;
            $display("FAIL cell_7_7: got %b required 01", bus.board[238 +: 2]);
        end
        place_at(7, 7, 2'b00);
    endtask

    task automatic test_row_win();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            place_at(3 + i, 5, 2'b00);
            place_at(2 * i, 0, 2'b00);
        end
        place_at(7, 5, 2'b01);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 0, 1);
        pulse(0, 1, 0, 0, 0);
        checks++;
        if (bus.pointer_loc_x !== 4'd7 || bus.pointer_loc_y !== 4'd5 || bus.board !== exp_board ||
            bus.gaming_status !== 2'b01 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL over_frozen: got ptr=(%0d,%0d) status=%b busy=%b board_ok=%b required (7,5) 01 0 1",
                     bus.pointer_loc_x, bus.pointer_loc_y, bus.gaming_status, bus.busy, bus.board === exp_board);
        end
        $display("over: ptr=(%0d,%0d) status=%b", bus.pointer_loc_x, bus.pointer_loc_y, bus.gaming_status);
    endtask

    task automatic test_anti_diag();
        int p1x [5] = '{10, 9, 7, 6, 8};
        int p1y [5] = '{0, 1, 3, 4, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            place_at(2 * i, 15, 2'b00);
            place_at(p1x[i], p1y[i], (i == 4) ? 2'b10 : 2'b00);
        end
    endtask

    task automatic test_overline_edge();
        int p0x [6] = '{0, 1, 2, 3, 5, 4};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            place_at(p0x[i], 0, 2'b00);
            place_at(2 * i, 10, 2'b00);
        end
        place_at(p0x[5], 0, 2'b01);
        // Row 12..15 on y=3 with a stone at (0,4) that a wrapping walk would count.
        do_reset();
        place_at(0, 4, 2'b00);
        for (int i = 0; i < 4; i++) begin
            place_at(2 * i, 12, 2'b00);
            place_at(12 + i, 3, 2'b00);
        end
    endtask

    task automatic test_reset_mid_check();
        do_reset();
        pulse(0, 0, 0, 0, 1);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_check_busy: got %b required 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.board !== '0 || bus.gaming_status !== 2'b00 || bus.pointer_loc_x !== 4'd7 ||
            bus.pointer_loc_y !== 4'd7 || bus.cur_player !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got status=%b ptr=(%0d,%0d) player=%b busy=%b board_nz=%b required 00 (7,7) 0 0 0",
                     bus.gaming_status, bus.pointer_loc_x, bus.pointer_loc_y, bus.cur_player, bus.busy, |bus.board);
        end
        $display("reset mid-check: busy=%b status=%b", bus.busy, bus.gaming_status);
    endtask

    // Colour ((x>>1)+y)&1 never gives a run longer than 2 in any direction.
    task automatic test_full_board();
        int zx [8];
        int ox [8];
        int nz, no;
        do_reset();
        for (int y = 0; y < 16; y++) begin
            nz = 0; no = 0;
            for (int x = 0; x < 16; x++) begin
                if ((((x >> 1) + y) & 1) == 0) begin zx[nz] = x; nz++; end
                else begin ox[no] = x; no++; end
            end
            for (int k = 0; k < 8; k++) begin
                place_at(zx[k], y, 2'b00);
                place_at(ox[k], y, (y == 15 && k == 7) ? 2'b11 : 2'b00);
            end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_cursor();
        test_place_turn();
        test_row_win();
        test_anti_diag();
        test_overline_edge();
        test_reset_mid_check();
        test_full_board();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gomoku_turn_ctrl.md
Name: gomoku_turn_ctrl

Overview:
Game sequencer that owns the 16x16 board register and drives the VGA renderer's board, gaming_status and pointer inputs. It moves the cursor from debounced key pulses and arbitrates turns between two players. It writes stones into the board and runs a multi-cycle five-in-a-row check after every placement. It replaces the switch-driven direct board writes in the top level.

Parameters:
BOARD_N, 16, cells per side; board width is BOARD_N*BOARD_N*2.
WIN_LEN, 5, consecutive stones needed to win.
PTR_X0, 7, cursor x after reset.
PTR_Y0, 7, cursor y after reset.

Ports:
CLOCK_50  in  1  system clock; all state changes on its rising edge.
Reset  in  1  asynchronous, active-low reset.
mv_up  in  1  single-cycle pulse; y-1.
mv_down  in  1  single-cycle pulse; y+1.
mv_left  in  1  single-cycle pulse; x-1.
mv_right  in  1  single-cycle pulse; x+1.
place  in  1  single-cycle pulse; place the current player's stone at the cursor.
board  out  512  cell (x,y) at bits [x*2 + y*32 +: 2]; 00 empty, 01 player 0, 10 player 1.
gaming_status  out  2  00 playing, 01 player 0 won, 10 player 1 won, 11 draw.
pointer_loc_x  out  4  cursor x.
pointer_loc_y  out  4  cursor y.
cur_player  out  1  player to move (0 places 01, 1 places 10).
busy  out  1  high while placing or checking.

Behaviour:
- Reset (Reset=0, asynchronous) sets:
  - board=0, gaming_status=00, pointer=(PTR_X0,PTR_Y0), cur_player=0, busy=0.
  - Stone count=0 and FSM=PLAY.
  - Reset mid-CHECK aborts the check with no status update.
- FSM states: PLAY, WRITE, CHECK, OVER.
- PLAY, cursor moves:
  - Only one move is applied per cycle, priority up>down>left>right.
  - The pointer saturates at 0 and BOARD_N-1; there is no wrap.
  - A move and place in the same cycle: the move is applied and place is dropped.
- PLAY, place:
  - place on an occupied cell is ignored: no write, no turn change, stays in PLAY.
  - place on an empty cell latches (px,py) = cursor and the stone code, then goes to WRITE.
- WRITE (1 cycle):
  - Writes the cell; the board shows the stone the cycle after WRITE.
  - Increments the 9-bit stone count and raises busy.
  - Enters CHECK, direction 0.
- CHECK, directions in order: d0=(+1,0), d1=(0,+1), d2=(+1,+1), d3=(+1,-1).
- CHECK, per direction:
  - Positive walk: up to WIN_LEN-1 steps from (px,py), one cell per cycle.
  - Negative walk: up to WIN_LEN-1 steps, one cell per cycle.
  - Each walk stops at the board edge (no wrap) or at the first non-matching cell; a terminating step still costs its cycle.
  - run = 1 + pos + neg, saturating at 2*WIN_LEN-1.
  - run >= WIN_LEN: gaming_status = stone code (01/10), go to OVER. Overlines (6+) count as wins.
- After d3 with no win:
  - Stone count == BOARD_N*BOARD_N: gaming_status=11, go to OVER.
  - Otherwise toggle cur_player, drop busy, return to PLAY.
- Latency: worst case place pulse to PLAY/OVER is 1 + 1 + 4*2*(WIN_LEN-1) + 1 = 35 cycles. The bench checks against the 35-cycle bound, not an exact count.
- While busy, all move and place pulses are ignored; they are not queued.
- OVER: board and pointer are frozen, busy=0, all inputs are ignored until Reset.
- gaming_status changes only on transitions into OVER and on reset.

Test Plan:
- Release reset -> board=0, status=00, pointer=(7,7), cur_player=0, busy=0 -> 8 mv_left pulses -> x saturates at 0; then mv_up and mv_down in the same cycle -> y=6 only.
- Place at (7,7) -> board[238+:2]=01, busy high for at most 34 cycles, then cur_player=1, status=00 -> place again at (7,7) -> no change, cur_player stays 1.
- Alternate moves so player 0 holds (3..7,5) with player 1 elsewhere -> after the fifth stone, status=01 within 35 cycles, FSM in OVER -> subsequent place/move pulses leave board and pointer unchanged.
- Player 1 anti-diagonal (10,0),(9,1),(8,2),(7,3),(6,4), placing (8,2) last (middle of the line) -> status=10.
- Player 0 row (0..3,0) and (5,0), then fill (4,0) -> run 6 -> status=01; row of 4 bounded by the board edge at x=15 -> no win.
- Assert Reset during CHECK -> outputs return to reset values immediately; scripted full-board fill with no line of 5 -> status=11 after the 256th stone.
